// File: rtl/fast_pix_stream_tx_if.sv
// Stream bundle shared by the word input and the pixel output of fast_pix_stream_tx.
//   tdata  : payload, DW bits
//   tvalid : source has a beat
//   tready : sink accepts the beat (transfer on tvalid && tready)
//   tlast  : end of row (pixel side only)
//   tuser  : start of frame (pixel side only)
// The master modport drives the beat; the slave modport drives tready.
interface fast_pix_stream_tx_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/fast_pix_stream_tx.sv
// Frame source for the FAST detector pixel input. Unpacks 32-bit words (byte 0 first) into
// 8-bit AXI-Stream beats, one frame per start, with tuser on the first pixel and tlast on
// each row end. The frame size is latched at start and held on out_w/out_h.
// Ports:
//   clk, rst_n     : clock (rising edge), synchronous active-low reset
//   start          : frame request, sampled only in IDLE, together with cfg_w/cfg_h
//   out_w, out_h   : latched frame size for the detector
//   busy, done     : frame in progress / one-cycle completion pulse
//   err            : sticky illegal-size flag, cleared by the next start
//   s_word         : 32-bit packed-pixel input stream (slave)
//   m_axis         : 8-bit pixel output stream (master), registered
module fast_pix_stream_tx #(
    parameter int unsigned MAX_W   = 640,
    parameter int unsigned MAX_H   = 428,
    parameter int unsigned ROW_GAP = 1,
    parameter int unsigned MIN_DIM = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0]                 cfg_w,
    input  logic [15:0]                 cfg_h,
    output logic [15:0]                 out_w,
    output logic [15:0]                 out_h,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    fast_pix_stream_tx_if.slave         s_word,
    fast_pix_stream_tx_if.master        m_axis
);

    localparam bit         GapEn   = (ROW_GAP != 0);
    localparam logic [3:0] GapLast = GapEn ? 4'(ROW_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic        buf_vld_q, buf_vld_d;
    logic [1:0]  idx_q, idx_d;
    logic [17:0] words_left_q, words_left_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        all_loaded_q, all_loaded_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic        eof_q, eof_d;  // current output beat is the frame's final pixel
    logic [15:0] w_q, w_d, h_q, h_d;
    logic        err_q, err_d;

    logic        cfg_ok, m_acc, load_slot, load, word_acc, word_rdy, row_end, frame_end;
    logic [7:0]  pix;
    logic [17:0] words_total;

    // Word-side sideband bits carry no meaning here.
    logic unused_word_sb;
    assign unused_word_sb = s_word.tlast ^ s_word.tuser;

    assign cfg_ok = (cfg_w >= 16'(MIN_DIM)) && (cfg_w <= 16'(MAX_W)) &&
                    (cfg_h >= 16'(MIN_DIM)) && (cfg_h <= 16'(MAX_H));
    assign words_total = 18'(((32'(cfg_w) * 32'(cfg_h)) + 32'd3) >> 2);

    assign m_acc = tvalid_q && m_axis.tready;

    // A new beat may enter the output register when it is free or being drained. With a row
    // gap, the row-end beat must drain before anything follows; the last gap cycle loads so
    // the next row starts exactly ROW_GAP idle cycles after the row end.
    assign load_slot = ((state_q == StRun) || ((state_q == StGap) && (gap_q == GapLast))) &&
                       (!tvalid_q || m_axis.tready) &&
                       !(GapEn && tvalid_q && tlast_q);
    assign load      = load_slot && buf_vld_q && !all_loaded_q;

    // Refill in the same cycle byte 3 leaves the buffer, keeping full rate across words.
    assign word_rdy  = ((state_q == StRun) || (state_q == StGap)) && (words_left_q != 18'd0) &&
                       (!buf_vld_q || (load && (idx_q == 2'd3)));
    assign word_acc  = s_word.tvalid && word_rdy;

    assign pix       = buf_q[{idx_q, 3'b000} +: 8];
    assign row_end   = (x_q == w_q - 16'd1);
    assign frame_end = row_end && (y_q == h_q - 16'd1);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_vld_d    = buf_vld_q;
        idx_d        = idx_q;
        words_left_d = words_left_q;
        x_d          = x_q;
        y_d          = y_q;
        all_loaded_d = all_loaded_q;
        gap_d        = gap_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        eof_d        = eof_q;
        w_d          = w_q;
        h_d          = h_q;
        err_d        = err_q;

        if (m_acc) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            eof_d    = 1'b0;
        end

        if (load) begin
            tdata_d  = pix;
            tvalid_d = 1'b1;
            tlast_d  = row_end;
            tuser_d  = (x_q == 16'd0) && (y_q == 16'd0);
            eof_d    = frame_end;
            idx_d    = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                buf_vld_d = 1'b0;
            end
            if (row_end) begin
                x_d = 16'd0;
                y_d = y_q + 16'd1;
                if (frame_end) begin
                    all_loaded_d = 1'b1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end
        end

        if (word_acc) begin
            buf_d        = s_word.tdata;
            buf_vld_d    = 1'b1;
            idx_d        = 2'd0;
            words_left_d = words_left_q - 18'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d          = cfg_w;
                    h_d          = cfg_h;
                    err_d        = !cfg_ok;
                    x_d          = 16'd0;
                    y_d          = 16'd0;
                    all_loaded_d = 1'b0;
                    gap_d        = 4'd0;
                    buf_vld_d    = 1'b0;
                    idx_d        = 2'd0;
                    words_left_d = cfg_ok ? words_total : 18'd0;
                    if (cfg_ok) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (m_acc && tlast_q) begin
                    if (eof_q) begin
                        state_d = StFin;
                    end else if (GapEn) begin
                        state_d = StGap;
                        gap_d   = 4'd0;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StRun;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StFin: begin
                // Leftover bytes of the final word are discarded here.
                state_d      = StIdle;
                buf_vld_d    = 1'b0;
                idx_d        = 2'd0;
                words_left_d = 18'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            buf_q        <= 32'd0;
            buf_vld_q    <= 1'b0;
            idx_q        <= 2'd0;
            words_left_q <= 18'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            all_loaded_q <= 1'b0;
            gap_q        <= 4'd0;
            tdata_q      <= 8'd0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            eof_q        <= 1'b0;
            w_q          <= 16'd0;
            h_q          <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            idx_q        <= idx_d;
            words_left_q <= words_left_d;
            x_q          <= x_d;
            y_q          <= y_d;
            all_loaded_q <= all_loaded_d;
            gap_q        <= gap_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            eof_q        <= eof_d;
            w_q          <= w_d;
            h_q          <= h_d;
            err_q        <= err_d;
        end
    end

    assign out_w         = w_q;
    assign out_h         = h_q;
    assign err           = err_q;
    assign busy          = (state_q == StRun) || (state_q == StGap);
    assign done          = (state_q == StFin);
    assign s_word.tready = word_rdy;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_fast_pix_stream_tx.sv
// Self-checking bench for fast_pix_stream_tx. dut0 (ROW_GAP=0) is checked by a scoreboard:
// frame tasks push expected beats, a negedge monitor pops and compares on each accepted beat.
// dut1 (ROW_GAP=2) checks row-gap spacing and frame-end timing.
module tb_fast_pix_stream_tx;

    logic        clk, rst_n, start0, start1;
    logic [15:0] cfg_w, cfg_h;
    logic [15:0] out_w0, out_h0, out_w1, out_h1;
    logic        busy0, done0, err0, busy1, done1, err1;

    fast_pix_stream_tx_if #(.DW(32)) w0 ();
    fast_pix_stream_tx_if #(.DW(8))  a0 ();
    fast_pix_stream_tx_if #(.DW(32)) w1 ();
    fast_pix_stream_tx_if #(.DW(8))  a1 ();

    fast_pix_stream_tx #(.ROW_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .out_w(out_w0), .out_h(out_h0), .busy(busy0), .done(done0), .err(err0),
        .s_word(w0), .m_axis(a0)
    );

    fast_pix_stream_tx #(.ROW_GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .out_w(out_w1), .out_h(out_h1), .busy(busy1), .done(done1), .err(err1),
        .s_word(w1), .m_axis(a1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- dut0 scoreboard and monitor ----------------
    logic [9:0] exp_q[$];  // {tdata, tlast, tuser}
    int  beat_cnt, wacc_cnt, done_cnt, first_cyc, last_cyc, done_cyc;
    bit  w_acc0;
    bit  hold0 = 1'b0;
    logic [9:0] held0;

    always @(negedge clk) begin
        w_acc0 = w0.tvalid && w0.tready;
        if (!rst_n) begin
            hold0 = 1'b0;
        end else begin
            if (w_acc0) wacc_cnt++;
            if (done0) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold0) chk("stall_hold", {a0.tvalid, a0.tdata, a0.tlast, a0.tuser}, {1'b1, held0});
            if (a0.tvalid && a0.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {a0.tdata, a0.tlast, a0.tuser}, 64'hFFFF);
                end else begin
                    chk($sformatf("beat%0d", beat_cnt), {a0.tdata, a0.tlast, a0.tuser},
                        exp_q.pop_front());
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
            end
            hold0 = a0.tvalid && !a0.tready;
            held0 = {a0.tdata, a0.tlast, a0.tuser};
        end
    end

    // ---------------- dut1 row-gap monitor ----------------
    logic [9:0] exp1_q[$];
    int  beats1, done1_cnt, gap_run1;
    bit  w_acc1;
    bit  after_last1 = 1'b0;

    always @(negedge clk) begin
        w_acc1 = w1.tvalid && w1.tready;
        if (!rst_n) begin
            after_last1 = 1'b0;
            gap_run1    = 0;
        end else if (done1) begin
            done1_cnt++;
            chk("gap_fin_no_gap", {31'd0, after_last1, gap_run1}, {31'd0, 1'b1, 32'd0});
            chk("gap_fin_beats", beats1, 64);
            after_last1 = 1'b0;
        end else if (a1.tvalid && a1.tready) begin
            if (exp1_q.size() == 0) begin
                chk("gap_unexpected_beat", {a1.tdata, a1.tlast, a1.tuser}, 64'hFFFF);
            end else begin
                chk($sformatf("gap_beat%0d", beats1), {a1.tdata, a1.tlast, a1.tuser},
                    exp1_q.pop_front());
            end
            if (after_last1) chk("row_gap", gap_run1, 2);
            after_last1 = a1.tlast;
            gap_run1    = 0;
            beats1++;
        end else if (after_last1) begin
            gap_run1++;
        end
    end

    function automatic logic [7:0] pix_val(input int base, input int i);
        return 8'((base + i) & 255);
    endfunction

    // Runs one frame on dut0. extra: words offered beyond the frame; abort_at: beat count at
    // which reset is asserted (0 = never); mid: pulse start with cfg_w=16 mid-frame.
    task automatic frame0(input int W, input int H, input int base, input bit rnd,
                          input int extra, input int abort_at, input bit mid);
        logic [31:0] words[$];
        logic [31:0] wd;
        int nw, total, wi, budget;
        bit mid_done;
        nw    = (W * H + 3) / 4;
        total = nw + extra;
        for (int k = 0; k < total; k++) begin
            for (int b = 0; b < 4; b++) wd[8*b +: 8] = pix_val(base, 4 * k + b);
            words.push_back(wd);
        end
        for (int i = 0; i < W * H; i++)
            exp_q.push_back({pix_val(base, i), (i % W) == W - 1, i == 0});
        beat_cnt = 0; wacc_cnt = 0; done_cnt = 0; wi = 0; mid_done = 1'b0;
        budget   = 4 * W * H + 200;

        cfg_w = 16'(W); cfg_h = 16'(H); start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        chk("start_busy", busy0, 1'b1);
        chk("start_err_clear", err0, 1'b0);
        @(posedge clk); #1;

        for (int n = 0; n < budget && done_cnt == 0; n++) begin
            if (!w0.tvalid && wi < total) w0.tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            w0.tdata  = (wi < total) ? words[wi] : 32'h0;
            a0.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid && !mid_done && beat_cnt >= 30) begin
                cfg_w = 16'd16; cfg_h = 16'd16; start0 = 1'b1; mid_done = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            if (abort_at > 0 && beat_cnt >= abort_at) begin
                rst_n = 1'b0;
                w0.tvalid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("reset_outputs", {out_w0, out_h0, busy0, done0, err0, a0.tvalid, a0.tdata,
                                      a0.tlast, a0.tuser, w0.tready}, 64'd0);
                exp_q.delete();
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (w_acc0) begin
                wi++;
                w0.tvalid = 1'b0;
            end
        end
        start0 = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        // Keep any extra word on offer to show it is never taken.
        repeat (5) @(posedge clk);
        #1;
        chk("words_accepted", wacc_cnt, nw);
        chk("done_pulses", done_cnt, 1);
        chk("exp_drained", exp_q.size(), 0);
        chk("out_w", out_w0, W);
        chk("out_h", out_h0, H);
        if (!rnd) begin
            chk("burst_len", last_cyc - first_cyc, W * H - 1);
            chk("done_latency", done_cyc - last_cyc, 1);
        end
        w0.tvalid = 1'b0;
        exp_q.delete();
    endtask

    task automatic frame1();
        logic [31:0] words[$];
        logic [31:0] wd;
        int wi;
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 4; b++) wd[8*b +: 8] = pix_val(8'h10, 4 * k + b);
            words.push_back(wd);
        end
        for (int i = 0; i < 64; i++)
            exp1_q.push_back({pix_val(8'h10, i), (i % 8) == 7, i == 0});
        beats1 = 0; done1_cnt = 0; wi = 0;
        a1.tready = 1'b1;
        cfg_w = 16'd8; cfg_h = 16'd8; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 0; n < 1000 && done1_cnt == 0; n++) begin
            w1.tvalid = (wi < 16);
            w1.tdata  = (wi < 16) ? words[wi] : 32'h0;
            @(posedge clk); #1;
            if (w_acc1) wi++;
        end
        chk("gap_done_seen", done1_cnt, 1);
        chk("gap_exp_drained", exp1_q.size(), 0);
        chk("gap_out_w", out_w1, 16'd8);
        w1.tvalid = 1'b0;
        exp1_q.delete();
    endtask

    task automatic bad_start(input int W, input int H);
        beat_cnt = 0; done_cnt = 0;
        a0.tready = 1'b1;
        cfg_w = 16'(W); cfg_h = 16'(H); start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        chk("err_set", err0, 1'b1);
        chk("err_busy_low", busy0, 1'b0);
        chk("err_latch_w", out_w0, W);
        chk("err_latch_h", out_h0, H);
        repeat (6) @(posedge clk);
        #1;
        chk("err_no_done", done_cnt, 0);
        chk("err_no_beat", beat_cnt + int'(a0.tvalid), 0);
        chk("err_sticky", err0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; cfg_w = 16'd0; cfg_h = 16'd0;
        w0.tvalid = 1'b0; w0.tdata = 32'h0; w0.tlast = 1'b0; w0.tuser = 1'b0;
        w1.tvalid = 1'b0; w1.tdata = 32'h0; w1.tlast = 1'b0; w1.tuser = 1'b0;
        a0.tready = 1'b0; a1.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {out_w0, out_h0, busy0, done0, err0, a0.tvalid, a0.tdata, a0.tlast,
                            a0.tuser, w0.tready}, 64'd0);
        chk("reset_state_d1", {busy1, done1, err1, a1.tvalid, w1.tready}, 64'd0);
        @(posedge clk); #1;

        frame0(8, 8, 8'h00, 1'b0, 0, 0, 1'b0);    // full-rate ramp
        frame0(9, 7, 8'h40, 1'b0, 1, 0, 1'b0);    // partial last word, 17th word refused
        frame0(8, 8, 8'h80, 1'b1, 0, 0, 1'b1);    // random stalls, start while busy
        frame1();                                 // ROW_GAP=2 spacing
        bad_start(641, 8);
        bad_start(8, 6);
        frame0(7, 7, 8'hC0, 1'b0, 0, 0, 1'b0);    // minimum size, clears err
        frame0(8, 8, 8'h20, 1'b0, 0, 20, 1'b0);   // reset mid-frame
        frame0(8, 8, 8'h00, 1'b0, 0, 0, 1'b0);    // full frame after reset
        frame0(640, 7, 8'h33, 1'b0, 0, 0, 1'b0);  // maximum width

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_pix_stream_tx.md
Name: fast_pix_stream_tx

Overview:
- Frame source that feeds the FAST detector's 8-bit pixel input.
- Takes 32-bit packed-pixel words from the DMA side, one frame per start.
- Emits one pixel per beat on AXI-Stream, with tuser on the frame's first pixel and tlast on each row's last pixel.
- Latches the frame size at start and presents it as stable cfg_w/cfg_h for the detector.

Parameters:
MAX_W, 640, largest legal frame width in pixels
MAX_H, 428, largest legal frame height in lines
ROW_GAP, 1, idle cycles (tvalid low) after each accepted row-end beat; range 0..15
MIN_DIM, 7, smallest legal width/height (the FAST 7x7 window)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to send a frame; sampled only in IDLE
cfg_w  in  16  frame width, sampled with start
cfg_h  in  16  frame height, sampled with start
out_w  out  16  latched width, to detector cfg_w
out_h  out  16  latched height, to detector cfg_h
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final pixel is accepted
err  out  1  sticky cfg error flag, cleared by the next start
s_word_tdata  in  32  four pixels, byte 0 (bits 7:0) sent first
s_word_tvalid  in  1  word valid
s_word_tready  out  1  word accepted when tvalid && tready
m_axis_tdata  out  8  pixel
m_axis_tvalid  out  1  pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of a row
m_axis_tuser  out  1  first pixel of the frame (SOF)

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0, FSM goes to IDLE, the word buffer is emptied, and a frame in flight is abandoned with no done.
- States:
  - IDLE: on start, latch cfg_w/cfg_h into out_w/out_h, clear err and the x/y counters.
    - If MIN_DIM <= W <= MAX_W and MIN_DIM <= H <= MAX_H, go to RUN.
    - Otherwise set err=1, stay in IDLE, and do not pulse busy or done.
  - RUN: consume words and emit pixels.
    - Acceptance of the row-end beat: go to GAP if ROW_GAP>0, else stay in RUN.
    - Acceptance of the last row's row-end beat: go to FIN.
  - GAP: hold m_axis_tvalid=0 for exactly ROW_GAP cycles, then return to RUN.
  - FIN: pulse done=1 for one cycle, drop busy, return to IDLE.
- out_w/out_h hold their value until the next accepted start, including through err.
- Packing: pixels are contiguous across rows. A frame is ceil(W*H/4) words; the unused upper bytes of the final word are discarded. No further words are accepted after the final word.
- Word buffer: one 32-bit register plus a 2-bit byte index.
  - s_word_tready=1 in RUN/GAP when the buffer is empty, or when byte 3 is being accepted this cycle.
  - The second case is combinational on m_axis_tready; this is required for full rate.
  - s_word_tready=0 in IDLE and FIN.
- Pixel output: m_axis_* are registered.
  - First m_axis_tvalid appears no earlier than the cycle after the first word is accepted.
  - While tvalid=1 and tready=0, tdata, tlast and tuser hold stable; tvalid never drops without acceptance.
- Throughput: with words always valid, m_axis_tready=1 and ROW_GAP=0, the block sustains one pixel per cycle with no bubbles across word or row boundaries.
- Flags:
  - tuser=1 only on the beat at x=0, y=0.
  - tlast=1 on beats with x=W-1.
  - Both are cleared when that beat is accepted.
- Counters: x is 0..W-1 and wraps to 0 with y+1 on tlast acceptance; y is 0..H-1. Both are 16-bit; no overflow is possible within the legal range.
- Edge cases:
  - start while busy is ignored; latched cfg is unchanged.
  - start in the same cycle as done is ignored; FSM is in FIN.
  - start is honoured from the next IDLE cycle.
  - A word arriving while the buffer is full stalls via tready=0; no data is lost.

Test Plan:
- 8x8, words 0x03020100.. (ramp 0..63), tready=1, ROW_GAP=0 -> 64 beats in 64 consecutive cycles; data 0..63; tuser only on beat 0; tlast on beats 7,15,…,63; 16 words accepted; done one cycle after beat 63; out_w=8, out_h=8.
- 9x7 frame (63 px) -> 16 words accepted; byte 3 of word 15 dropped; the 17th word offered is never accepted (tready=0); tlast on beats 8,17,…,62.
- 8x8 with random m_axis_tready (50%) and random s_word_tvalid gaps -> identical ordered pixel sequence; tdata/tlast/tuser stable during each stall.
- ROW_GAP=2, 8x8, tready=1 -> exactly 2 idle cycles after each of rows 0..6; none after row 7; done follows.
- start with cfg_w=641 (and separately cfg_h=6) -> err=1, busy=0, no tvalid, no done; next valid start clears err.
- Reset asserted at beat 20 of 8x8 -> next cycle all outputs 0 and IDLE; start of a new frame then sends its full 64 beats with tuser on beat 0.
- start pulsed while busy mid-frame with cfg_w=16 -> ignored; out_w stays 8.
